// File: rtl/clkdiv_pkg.sv
// ----------------------------------------------------------------------------
// clkdiv_pkg : shared width, divisor type and reset divisor for multi_clock_div
// Revision   : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package clkdiv_pkg;

  localparam int CLKDIV_WIDTH = 32;

  typedef logic [CLKDIV_WIDTH-1:0] div_t;

  // 1 kHz slowCLK from a 100 MHz board clock
  localparam div_t CLKDIV_DEFAULT_DIV = div_t'(49999);

endpackage

`default_nettype wire

// File: rtl/clkdiv_channel.sv
// ----------------------------------------------------------------------------
// clkdiv_channel : one divider lane with shadowed divisor, toggle clock + tick
// Optional macro  : CLKDIV_SYNC_EN adds syncIn phase alignment
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int               WIDTH       = CLKDIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLKDIV_DEFAULT_DIV)
) (
  input  logic             fastCLK,
  input  logic             reset_n,
  input  logic             en,
  input  logic             load,
`ifdef CLKDIV_SYNC_EN
  input  logic             syncIn,
`endif
  input  logic [WIDTH-1:0] divIn,
  output logic             slowCLK,
  output logic             tick,
  output logic             pending
);

  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_shadow;
  logic             r_pending;
  logic             r_slow;
  logic             r_tick;
  logic             w_wrap;

  assign w_wrap = (r_counter == r_active);

  always_ff @(posedge fastCLK) begin
    if (!reset_n) begin
      r_counter <= '0;
      r_active  <= DEFAULT_DIV;
      r_shadow  <= DEFAULT_DIV;
      r_pending <= 1'b0;
      r_slow    <= 1'b0;
      r_tick    <= 1'b0;
    end
`ifdef CLKDIV_SYNC_EN
    else if (syncIn && en) begin
      r_counter <= '0;
      r_slow    <= 1'b0;
      r_tick    <= 1'b0;
      if (r_pending) r_active <= r_shadow;
      // A same-edge load lands in the shadow for the next wrap
      r_pending <= load;
      if (load) r_shadow <= divIn;
    end
`endif
    else if (!en) begin
      r_counter <= '0;
      r_slow    <= 1'b0;
      r_tick    <= 1'b0;
      r_pending <= 1'b0;
      if (load) begin
        r_active <= divIn;
        r_shadow <= divIn;
      end else if (r_pending) begin
        r_active <= r_shadow;
      end
    end else begin
      if (w_wrap) begin
        r_counter <= '0;
        r_slow    <= ~r_slow;
        r_tick    <= 1'b1;
        if (r_pending) begin
          r_active  <= r_shadow;
          r_pending <= 1'b0;
        end
      end else begin
        r_counter <= r_counter + 1'b1;
        r_tick    <= 1'b0;
      end
      // Load overrides the pending clear so a wrap-edge load waits a period
      if (load) begin
        r_shadow  <= divIn;
        r_pending <= 1'b1;
      end
    end
  end

  assign slowCLK = r_slow;
  assign tick    = r_tick;
  assign pending = r_pending;

endmodule

`default_nettype wire

// File: rtl/multi_clock_div.sv
// ----------------------------------------------------------------------------
// multi_clock_div : NUM_CH independent runtime-programmable clock dividers
// Optional macro  : CLKDIV_SYNC_EN adds syncIn to phase-align all channels
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multi_clock_div
  import clkdiv_pkg::*;
#(
  parameter int               NUM_CH      = 4,
  parameter int               WIDTH       = CLKDIV_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(CLKDIV_DEFAULT_DIV)
) (
  input  logic                    fastCLK,
  input  logic                    reset_n,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       load,
`ifdef CLKDIV_SYNC_EN
  input  logic                    syncIn,
`endif
  input  logic [NUM_CH*WIDTH-1:0] divIn,
  output logic [NUM_CH-1:0]       slowCLK,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clkdiv_channel #(
      .WIDTH      (WIDTH),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_channel (
      .fastCLK(fastCLK),
      .reset_n(reset_n),
      .en     (en[i]),
      .load   (load[i]),
`ifdef CLKDIV_SYNC_EN
      .syncIn (syncIn),
`endif
      .divIn  (divIn[i*WIDTH +: WIDTH]),
      .slowCLK(slowCLK[i]),
      .tick   (tick[i]),
      .pending(pending[i])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_clock_div.sv
// ----------------------------------------------------------------------------
// tb_multi_clock_div : scoreboard bench for multi_clock_div
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multi_clock_div;

  localparam int NUM_CH  = 4;
  localparam int WIDTH   = 32;
  localparam int DEF_DIV = 49999;

  logic                    fastCLK;
  logic                    reset_n;
  logic [NUM_CH-1:0]       en;
  logic [NUM_CH-1:0]       load;
  logic [NUM_CH*WIDTH-1:0] divIn;
  logic [NUM_CH-1:0]       slowCLK;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       pending;
`ifdef CLKDIV_SYNC_EN
  logic                    syncIn;
`endif

  multi_clock_div #(
    .NUM_CH(NUM_CH),
    .WIDTH (WIDTH)
  ) dut (
    .fastCLK(fastCLK),
    .reset_n(reset_n),
    .en     (en),
    .load   (load),
`ifdef CLKDIV_SYNC_EN
    .syncIn (syncIn),
`endif
    .divIn  (divIn),
    .slowCLK(slowCLK),
    .tick   (tick),
    .pending(pending)
  );

  initial fastCLK = 1'b0;
  always #5 fastCLK = ~fastCLK;

  typedef struct {
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] t;
    logic [NUM_CH-1:0] p;
  } exp_t;

  exp_t  sbq[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc    = 0;
  string tname  = "init";

  task automatic pushx(input logic [NUM_CH-1:0] m, input logic [NUM_CH-1:0] s,
                       input logic [NUM_CH-1:0] t, input logic [NUM_CH-1:0] p);
    exp_t e;
    e.mask = m; e.s = s; e.t = t; e.p = p;
    sbq.push_back(e);
  endtask

  task automatic push1(input int ch, input logic s, input logic t, input logic p);
    logic [NUM_CH-1:0] m;
    m = NUM_CH'(1) << ch;
    pushx(m, s ? m : '0, t ? m : '0, p ? m : '0);
  endtask

  task automatic set_div(input int ch, input int d);
    divIn[ch*WIDTH +: WIDTH] = d;
  endtask

  // One edge per entry: sample #1 after the edge and compare the masked bits
  task automatic run_cycles(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge fastCLK);
      #1;
      cyc++;
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s scoreboard empty at cycle %0d", tname, cyc);
      end else begin
        e = sbq.pop_front();
        if (e.mask != '0) begin
          checks++;
          if ((slowCLK & e.mask) !== (e.s & e.mask) ||
              (tick    & e.mask) !== (e.t & e.mask) ||
              (pending & e.mask) !== (e.p & e.mask)) begin
            errors++;
            $display("FAIL %s cycle %0d mask=%b slowCLK got %b want %b, tick got %b want %b, pending got %b want %b",
                     tname, cyc, e.mask, slowCLK & e.mask, e.s & e.mask,
                     tick & e.mask, e.t & e.mask, pending & e.mask, e.p & e.mask);
          end
        end
      end
    end
  endtask

  task automatic load_idle(input int ch, input int d);
    load[ch] = 1'b1;
    set_div(ch, d);
    push1(ch, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
    load[ch] = 1'b0;
  endtask

  task automatic test_reset();
    tname = "reset";
    pushx('1, '0, '0, '0);
    pushx('1, '0, '0, '0);
    run_cycles(2);
    reset_n = 1'b1;
    pushx('1, '0, '0, '0);
    run_cycles(1);
  endtask

  task automatic test_divide();
    tname = "divide_d3";
    load_idle(0, 3);
    for (int k = 1; k <= 16; k++)
      push1(0, ((k / 4) % 2) == 1, (k % 4) == 0, 1'b0);
    en[0] = 1'b1;
    run_cycles(16);
    en[0] = 1'b0;
    push1(0, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
  endtask

  task automatic test_midload();
    tname = "midload_d5_to_d1";
    load_idle(1, 5);
    for (int k = 1; k <= 6; k++)
      push1(1, ((k / 6) % 2) == 1, (k % 6) == 0, (k == 4) || (k == 5));
    for (int j = 1; j <= 8; j++)
      push1(1, ((j / 2) % 2) == 0, (j % 2) == 0, 1'b0);
    en[1] = 1'b1;
    run_cycles(3);
    load[1] = 1'b1;
    set_div(1, 1);
    run_cycles(1);
    load[1] = 1'b0;
    run_cycles(10);
    en[1] = 1'b0;
    push1(1, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
  endtask

  task automatic test_back_to_back();
    tname = "wrap_edge_load";
    load_idle(3, 4);
    for (int k = 1; k <= 10; k++)
      push1(3, ((k / 5) % 2) == 1, (k % 5) == 0, (k >= 5) && (k < 10));
    for (int j = 1; j <= 9; j++)
      push1(3, ((j / 3) % 2) == 1, (j % 3) == 0, 1'b0);
    en[3] = 1'b1;
    run_cycles(4);
    load[3] = 1'b1;
    set_div(3, 2);
    run_cycles(1);
    load[3] = 1'b0;
    run_cycles(14);
    en[3] = 1'b0;
    push1(3, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
  endtask

  task automatic test_div_zero();
    tname = "div_zero";
    load_idle(2, 0);
    for (int k = 1; k <= 6; k++)
      push1(2, (k % 2) == 1, 1'b1, 1'b0);
    en[2] = 1'b1;
    run_cycles(6);
    tname = "div_zero_disable";
    en[2] = 1'b0;
    push1(2, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
  endtask

  task automatic test_reset_midload();
    tname = "reset_midload";
    load_idle(0, 3);
    push1(0, 1'b0, 1'b0, 1'b0);
    push1(0, 1'b0, 1'b0, 1'b0);
    en[0] = 1'b1;
    run_cycles(2);
    load[0] = 1'b1;
    set_div(0, 9);
    push1(0, 1'b0, 1'b0, 1'b1);
    run_cycles(1);
    reset_n = 1'b0;
    pushx('1, '0, '0, '0);
    run_cycles(1);
    reset_n = 1'b1;
    load[0] = 1'b0;
    tname = "default_div_after_reset";
    for (int k = 1; k <= DEF_DIV + 2; k++)
      push1(0, ((k / (DEF_DIV + 1)) % 2) == 1, (k % (DEF_DIV + 1)) == 0, 1'b0);
    run_cycles(DEF_DIV + 2);
    en[0] = 1'b0;
    push1(0, 1'b0, 1'b0, 1'b0);
    run_cycles(1);
  endtask

`ifdef CLKDIV_SYNC_EN
  task automatic test_sync();
    logic [NUM_CH-1:0] s;
    logic [NUM_CH-1:0] t;
    tname = "sync";
    load[0] = 1'b1; load[1] = 1'b1;
    set_div(0, 3);  set_div(1, 7);
    pushx(4'b0011, '0, '0, '0);
    run_cycles(1);
    load[0] = 1'b0; load[1] = 1'b0;
    en[0] = 1'b1;
    for (int k = 0; k < 5; k++) pushx('0, '0, '0, '0);
    run_cycles(3);
    en[1] = 1'b1;
    run_cycles(2);
    syncIn = 1'b1;
    pushx(4'b0011, '0, '0, '0);
    run_cycles(1);
    syncIn = 1'b0;
    for (int j = 1; j <= 16; j++) begin
      s = '0;
      t = '0;
      s[0] = ((j / 4) % 2) == 1;
      t[0] = (j % 4) == 0;
      s[1] = ((j / 8) % 2) == 1;
      t[1] = (j % 8) == 0;
      pushx(4'b0011, s, t, '0);
    end
    run_cycles(16);
    en[0] = 1'b0; en[1] = 1'b0;
    pushx(4'b0011, '0, '0, '0);
    run_cycles(1);
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    en      = '0;
    load    = '0;
    divIn   = '0;
`ifdef CLKDIV_SYNC_EN
    syncIn  = 1'b0;
`endif
    test_reset();
    test_divide();
    test_midload();
    test_back_to_back();
    test_div_zero();
    test_reset_midload();
`ifdef CLKDIV_SYNC_EN
    test_sync();
`endif
    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover entries got %0d want 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
